// File: rtl/gptp_tx_pkg.sv
// Shared types and constants for the gPTP tx frame stamper.
package gptp_tx_pkg;
   localparam int SEC_W      = 48;
   localparam int NS_W       = 32;
   localparam int TS_W       = 80;
   localparam int DESC_BYTES = 10;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SFD,
      ST_ADDR,
      ST_DATA,
      ST_STAMP,
      ST_IFG
   } tx_state_e;
endpackage

// File: rtl/ts_ns_adder.sv
// Registered egress-latency correction: adds LATENCY_NS to {sec, ns} with ns rollover
// and modulo-2^48 seconds wrap. Used only when TX_TS_CORR_EN is defined.
module ts_ns_adder
   import gptp_tx_pkg::*;
#(
   parameter logic [31:0] LATENCY_NS = 32'd96,
   parameter logic [31:0] NS_PER_SEC = 32'd1000000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [TS_W-1:0] ts_in,
   output logic [TS_W-1:0] ts_out
);
   logic [NS_W:0]    sum;
   logic [NS_W:0]    wrapped;
   logic [SEC_W-1:0] sec_inc;

   always_comb begin
      sum     = {1'b0, ts_in[NS_W-1:0]} + {1'b0, LATENCY_NS};
      wrapped = sum - {1'b0, NS_PER_SEC};
      sec_inc = ts_in[TS_W-1:NS_W] + {{(SEC_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ts_out <= '0;
      else if (sum >= {1'b0, NS_PER_SEC})
         ts_out <= {sec_inc, wrapped[NS_W-1:0]};
      else
         ts_out <= {ts_in[TS_W-1:NS_W], sum[NS_W-1:0]};
   end
endmodule

// File: rtl/tx_frame_stamper.sv
// Serialises a descriptor into a MAC byte frame and returns the SFD egress time.
// TX_TS_CORR_EN: when defined, the returned time includes TX_LATENCY_NS with ns rollover.
module tx_frame_stamper
   import gptp_tx_pkg::*;
#(
   parameter int          PREAMBLE_LEN  = 7,
   parameter int          IFG_CYCLES    = 12,
   parameter logic [31:0] TX_LATENCY_NS = 32'd96,
   parameter logic [31:0] NS_PER_SEC    = 32'd1000000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  send_addr,
   input  logic        send_vaild,
   output logic        send_ready,
   input  logic [79:0] send_data,
   output logic        send_r_vaild,
   output logic [79:0] send_r_data,
   input  logic [79:0] rtc_time,
   output logic [7:0]  mac_tx_data,
   output logic        mac_tx_valid,
   output logic        mac_tx_last,
   input  logic        mac_tx_ready
);
   localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_LEN - 1);
   localparam logic [15:0] DATA_LAST = 16'(DESC_BYTES - 1);
   localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 1);

   tx_state_e        state;
   logic [15:0]      cnt;
   logic [7:0]       addr_q;
   logic [79:0]      desc_sh;
   logic [TS_W-1:0]  cap;
   logic [TS_W-1:0]  ts;
   logic             xfer;

   // Byte outputs decode straight from registered state, so they stay stable
   // while the MAC stalls and drop to zero the moment reset hits.
   always_comb begin
      mac_tx_valid = 1'b0;
      mac_tx_data  = 8'h00;
      mac_tx_last  = 1'b0;
      case (state)
         ST_PRE:  begin mac_tx_valid = 1'b1; mac_tx_data = PREAMBLE_BYTE; end
         ST_SFD:  begin mac_tx_valid = 1'b1; mac_tx_data = SFD_BYTE; end
         ST_ADDR: begin mac_tx_valid = 1'b1; mac_tx_data = addr_q; end
         ST_DATA: begin
            mac_tx_valid = 1'b1;
            mac_tx_data  = desc_sh[79:72];
            mac_tx_last  = (cnt == DATA_LAST);
         end
         default: ;
      endcase
   end

   assign xfer = mac_tx_valid & mac_tx_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         desc_sh      <= '0;
         cap          <= '0;
         send_ready   <= 1'b0;
         send_r_vaild <= 1'b0;
         send_r_data  <= '0;
      end else begin
         send_r_vaild <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (send_ready && send_vaild) begin
                  addr_q     <= send_addr;
                  desc_sh    <= send_data;
                  send_ready <= 1'b0;
                  cnt        <= '0;
                  state      <= ST_PRE;
               end else begin
                  send_ready <= 1'b1;
               end
            end
            ST_PRE: if (xfer) begin
               if (cnt == PRE_LAST) begin
                  cnt   <= '0;
                  state <= ST_SFD;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_SFD: if (xfer) begin
               cap   <= rtc_time;
               state <= ST_ADDR;
            end
            ST_ADDR: if (xfer) begin
               cnt   <= '0;
               state <= ST_DATA;
            end
            ST_DATA: if (xfer) begin
               desc_sh <= {desc_sh[71:0], 8'h00};
               if (cnt == DATA_LAST) begin
                  // corrected time has long settled: SFD capture was >= 11 edges ago
                  cnt          <= '0;
                  send_r_vaild <= 1'b1;
                  send_r_data  <= ts;
                  state        <= ST_STAMP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_STAMP: begin
               cnt   <= '0;
               state <= ST_IFG;
            end
            ST_IFG: begin
               if (cnt == IFG_LAST) begin
                  cnt        <= '0;
                  send_ready <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef TX_TS_CORR_EN
   ts_ns_adder #(
      .LATENCY_NS (TX_LATENCY_NS),
      .NS_PER_SEC (NS_PER_SEC)
   ) u_ts_ns_adder (
      .clk    (clk),
      .reset  (reset),
      .ts_in  (cap),
      .ts_out (ts)
   );
`else
   assign ts = cap;
`endif
endmodule

// File: tb/tb_tx_frame_stamper.sv
// Directed bench for tx_frame_stamper: frame bytes, timestamps, backpressure, b2b, reset.
module tb_tx_frame_stamper;
   localparam int PRE_LEN = 7;
   localparam int IFG     = 12;
`ifdef TX_TS_CORR_EN
   localparam bit CORR = 1'b1;
`else
   localparam bit CORR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  send_addr = '0;
   logic        send_vaild = 1'b0;
   logic        send_ready;
   logic [79:0] send_data = '0;
   logic        send_r_vaild;
   logic [79:0] send_r_data;
   logic [79:0] rtc_time = '0;
   logic [7:0]  mac_tx_data;
   logic        mac_tx_valid;
   logic        mac_tx_last;
   logic        mac_tx_ready = 1'b1;

   tx_frame_stamper #(
      .PREAMBLE_LEN (PRE_LEN),
      .IFG_CYCLES   (IFG)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .send_addr    (send_addr),
      .send_vaild   (send_vaild),
      .send_ready   (send_ready),
      .send_data    (send_data),
      .send_r_vaild (send_r_vaild),
      .send_r_data  (send_r_data),
      .rtc_time     (rtc_time),
      .mac_tx_data  (mac_tx_data),
      .mac_tx_valid (mac_tx_valid),
      .mac_tx_last  (mac_tx_last),
      .mac_tx_ready (mac_tx_ready)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Bus monitor, sampled on the falling edge
   int          cyc = 0;
   logic [7:0]  q_bytes[$];
   bit          q_last[$];
   int          q_lastcyc[$];
   int          q_acc[$];
   int          byte_idx = 0;
   int          n_pulse = 0;
   int          hold_err = 0;
   int          rdy_since = 0;
   int          rdy_gap = -1;
   logic [79:0] sfd_rtc = '0;
   logic        prev_v = 1'b0, prev_r = 1'b0;
   logic [7:0]  prev_d = '0;
   bit          rtc_run = 1'b0, bp_mode = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset) begin
         byte_idx <= 0;
         prev_v   <= 1'b0;
      end else begin
         if (prev_v && !prev_r && (!mac_tx_valid || mac_tx_data != prev_d))
            hold_err <= hold_err + 1;
         prev_v <= mac_tx_valid;
         prev_r <= mac_tx_ready;
         prev_d <= mac_tx_data;
         if (mac_tx_valid && mac_tx_ready) begin
            q_bytes.push_back(mac_tx_data);
            q_last.push_back(mac_tx_last);
            if (byte_idx == PRE_LEN) sfd_rtc <= rtc_time;
            if (mac_tx_last) q_lastcyc.push_back(cyc);
            byte_idx <= mac_tx_last ? 0 : byte_idx + 1;
         end
         if (send_r_vaild) n_pulse <= n_pulse + 1;
         if (send_vaild && send_ready) begin
            q_acc.push_back(cyc);
            rdy_gap   <= rdy_since;
            rdy_since <= 0;
         end else if (send_ready) begin
            rdy_since <= rdy_since + 1;
         end
      end
   end

   // Free-running rtc and ready toggling for the backpressure case
   initial forever begin
      @(posedge clk);
      #1;
      if (rtc_run) rtc_time[31:0] = rtc_time[31:0] + 32'd1;
      if (bp_mode) mac_tx_ready = ~mac_tx_ready;
   end

   task automatic clear_bus();
      q_bytes.delete();
      q_last.delete();
   endtask

   task automatic offer(input logic [7:0] a, input logic [79:0] d);
      int n0 = q_acc.size();
      send_addr  = a;
      send_data  = d;
      send_vaild = 1'b1;
      for (int i = 0; i < 300 && q_acc.size() == n0; i++) @(posedge clk);
      #1;
      send_vaild = 1'b0;
      if (q_acc.size() == n0) chk("accept_timeout", 80'd0, 80'd1);
   endtask

   task automatic wait_pulse(input int target);
      for (int i = 0; i < 600 && n_pulse < target; i++) @(posedge clk);
      if (n_pulse < target) chk("pulse_timeout", 80'(n_pulse), 80'(target));
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input logic [7:0] a, input logic [79:0] d);
      logic [7:0] e;
      chk("frame_len", 80'(q_bytes.size()), 80'(PRE_LEN + 12));
      for (int i = 0; i < q_bytes.size() && i < PRE_LEN + 12; i++) begin
         if (i < PRE_LEN)          e = 8'h55;
         else if (i == PRE_LEN)    e = 8'hD5;
         else if (i == PRE_LEN+1)  e = a;
         else                      e = d[8*(PRE_LEN+11-i) +: 8];
         chk($sformatf("byte%0d", i), {71'd0, q_last[i], q_bytes[i]},
             {71'd0, (i == PRE_LEN + 11), e});
      end
   endtask

   logic [79:0] d0, d1, exp_ts;
   int          np, nl, na;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      #12;
      chk("rst_ctl", {75'd0, send_ready, send_r_vaild, mac_tx_valid, mac_tx_last, 1'b0},
          80'd0);
      chk("rst_bytes", {72'd0, mac_tx_data}, 80'd0);
      chk("rst_ts", send_r_data, 80'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("ready_idle", {79'd0, send_ready}, 80'd1);

      // basic frame
      d0 = 80'h123456789abc00000001;
      rtc_time = {48'h10, 32'd500};
      clear_bus();
      offer(8'd1, d0);
      wait_pulse(1);
      check_frame(8'd1, d0);
      chk("basic_ts", send_r_data, CORR ? {48'h10, 32'd596} : {48'h10, 32'd500});
      chk("basic_pulses", 80'(n_pulse), 80'd1);

      // ns rollover
      rtc_time = {48'h5, 32'd999999950};
      offer(8'd2, 80'h00000000000000000002);
      wait_pulse(2);
      chk("roll_ts", send_r_data, CORR ? {48'h6, 32'd46} : {48'h5, 32'd999999950});

      // seconds wrap
      rtc_time = {48'hFFFFFFFFFFFF, 32'd999999990};
      offer(8'd3, 80'h00000000000000000003);
      wait_pulse(3);
      chk("wrap_ts", send_r_data,
          CORR ? {48'h0, 32'd86} : {48'hFFFFFFFFFFFF, 32'd999999990});

      // backpressure with a moving rtc
      d0 = 80'hd5a55a0102030405fe80;
      rtc_time = {48'h7, 32'd1000};
      clear_bus();
      rtc_run = 1'b1;
      bp_mode = 1'b1;
      offer(8'h44, d0);
      wait_pulse(4);
      bp_mode = 1'b0;
      rtc_run = 1'b0;
      mac_tx_ready = 1'b1;
      check_frame(8'h44, d0);
      chk("bp_hold", 80'(hold_err), 80'd0);
      exp_ts = CORR ? {sfd_rtc[79:32], sfd_rtc[31:0] + 32'd96} : sfd_rtc;
      chk("bp_ts", send_r_data, exp_ts);

      // back-to-back with send_vaild held high
      d0 = 80'h0a0b0c0d0e0f10111213;
      d1 = 80'hf0e0d0c0b0a090807060;
      rtc_time = {48'h20, 32'd0};
      na = q_acc.size();
      nl = q_lastcyc.size();
      np = n_pulse;
      send_addr  = 8'h11;
      send_data  = d0;
      send_vaild = 1'b1;
      for (int i = 0; i < 300 && q_acc.size() == na; i++) @(posedge clk);
      #1;
      send_addr = 8'h22;
      send_data = d1;
      for (int i = 0; i < 300 && q_acc.size() < na + 2; i++) @(posedge clk);
      #1;
      send_vaild = 1'b0;
      if (q_acc.size() < na + 2) chk("b2b_timeout", 80'(q_acc.size()), 80'(na + 2));
      else begin
         chk("b2b_gap", 80'(q_acc[na+1] - q_lastcyc[nl]), 80'(IFG + 2));
         chk("b2b_period", 80'(q_acc[na+1] - q_acc[na]), 80'(PRE_LEN + 12 + 2 + IFG));
         chk("b2b_ready_low", 80'(rdy_gap), 80'd0);
      end
      wait_pulse(np + 2);
      chk("b2b_pulses", 80'(n_pulse), 80'(np + 2));
      chk("b2b_ts", send_r_data, CORR ? {48'h20, 32'd96} : {48'h20, 32'd0});

      // reset during DATA
      rtc_time = {48'h3, 32'd100};
      clear_bus();
      np = n_pulse;
      offer(8'h33, 80'h11111111111111111111);
      for (int i = 0; i < 100 && byte_idx < PRE_LEN + 5; i++) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_ctl", {75'd0, send_ready, send_r_vaild, mac_tx_valid, mac_tx_last, 1'b0},
          80'd0);
      chk("mid_rst_bytes", {72'd0, mac_tx_data}, 80'd0);
      chk("mid_rst_ts", send_r_data, 80'd0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("mid_rst_no_pulse", 80'(n_pulse), 80'(np));
      chk("mid_rst_ready", {79'd0, send_ready}, 80'd1);
      d0 = 80'h99887766554433221100;
      rtc_time = {48'h3, 32'd200};
      clear_bus();
      offer(8'h55, d0);
      wait_pulse(np + 1);
      check_frame(8'h55, d0);
      chk("post_rst_ts", send_r_data, CORR ? {48'h3, 32'd296} : {48'h3, 32'd200});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/tx_frame_stamper.md
Name: tx_frame_stamper

Overview:
- Downstream consumer of the tx timestamp buffer. Accepts one 80-bit descriptor plus 8-bit slot address per handshake on the send_* interface.
- Serialises the descriptor as a byte frame onto the MAC tx stream.
- Captures the egress time at the SFD byte and returns it to the buffer on send_r_vaild/send_r_data, so gPTP can read it back by slot.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD (1..15).
- IFG_CYCLES, 12, idle cycles after frame end before the next accept (>=1).
- TX_LATENCY_NS, 32'd96, PHY egress latency added to the captured ns field.
- NS_PER_SEC, 32'd1000000000, ns rollover value.

Ports:
- clk  in  1  block clock
- reset  in  1  asynchronous, active-high reset
- send_addr  in  8  buffer slot address of the offered descriptor
- send_vaild  in  1  descriptor offered
- send_ready  out  1  stamper can accept
- send_data  in  80  descriptor {sec[47:0], ns/seq[31:0]}
- send_r_vaild  out  1  one-cycle pulse: timestamp valid
- send_r_data  out  80  egress timestamp {sec[47:0], ns[31:0]}
- rtc_time  in  80  free-running local time {sec[47:0], ns[31:0]}, ns < NS_PER_SEC
- mac_tx_data  out  8  frame byte
- mac_tx_valid  out  1  byte valid
- mac_tx_last  out  1  final byte of frame
- mac_tx_ready  in  1  MAC accepts byte

Behaviour:
- Reset values: all outputs 0; internal registers 0; FSM=IDLE. Reset asserted mid-frame aborts immediately; no timestamp is returned for the aborted frame.
- FSM states: IDLE, PRE, SFD, ADDR, DATA, STAMP, IFG.
- IDLE:
  - send_ready=1 (registered, asserts the cycle IDLE is entered).
  - On send_vaild&send_ready: latch addr and data, go to PRE; send_ready falls the next cycle.
- PRE:
  - mac_tx_data=0x55, mac_tx_valid=1.
  - Byte counter advances only on mac_tx_valid&mac_tx_ready.
  - After PREAMBLE_LEN accepted bytes, go to SFD.
- SFD:
  - Byte is 0xD5.
  - On acceptance, latch rtc_time of that cycle (raw capture), then go to ADDR.
- ADDR: one byte, the latched addr.
- DATA:
  - 10 bytes, send_data[79:72] first, down to [7:0].
  - mac_tx_last=1 on the 10th byte only.
- STAMP:
  - Entered the cycle after the last byte is accepted.
  - Drives send_r_vaild=1 for exactly one cycle; send_r_data is updated in the same cycle and held until the next pulse.
  - Then go to IFG.
- IFG: mac_tx_valid=0 for IFG_CYCLES cycles, then IDLE.
- mac_tx_valid, once asserted, stays high with stable data until accepted (AXI-stream rule). mac_tx_ready low stalls any byte state indefinitely.
- Minimum frame = PREAMBLE_LEN+12 bytes; minimum accept-to-accept period = frame bytes + 1 (STAMP) + IFG_CYCLES + 1 (IDLE).
- Timestamp arithmetic (correction enabled):
  - ns' = ns + TX_LATENCY_NS (33-bit sum).
  - If ns' >= NS_PER_SEC: ns' -= NS_PER_SEC and sec' = sec + 1. Otherwise sec unchanged.
  - sec wraps modulo 2^48 (0xFFFFFFFFFFFF + 1 -> 0).
  - The correction is registered between the SFD capture and STAMP. It must be complete before STAMP, which is always at least 11 cycles later.
- send_vaild high during non-IDLE states is ignored (no accept); the buffer holds it.

Optional Feature:
- Macro: TX_TS_CORR_EN.
- Defined: TX_LATENCY_NS correction and ns rollover applied as above.
- Undefined: send_r_data is the raw rtc_time captured at SFD acceptance; the adder and compare logic are compiled out.

Decomposition:
- Shared package gptp_tx_pkg:
  - FSM state enum.
  - PREAMBLE_BYTE=8'h55 and SFD_BYTE=8'hD5.
  - Timestamp widths SEC_W=48, NS_W=32, TS_W=80.
  - DESC_BYTES=10.
- One sub-module, ts_ns_adder: registered sec/ns + latency with rollover. Instantiated only under TX_TS_CORR_EN.

Test Plan:
- Basic frame:
  - Stimulus: addr=8'd1, data=80'h123456789abc00000001, mac_tx_ready=1, rtc_time={48'h10,32'd500}.
  - Required: mac_tx_data sequence 7x55, D5, 01, 12 34 56 78 9A BC 00 00 00 01; mac_tx_last on the final 01; one send_r_vaild pulse with send_r_data={48'h10,32'd596}.
- ns rollover:
  - Stimulus: rtc ns=999999950 at SFD.
  - Required: send_r_data={sec+1, 32'd46}. Also sec=48'hFFFFFFFFFFFF wraps to 0.
- Backpressure:
  - Stimulus: mac_tx_ready toggled 1/0 each cycle.
  - Required: every byte is held while ready=0; byte order unchanged; timestamp is taken at the SFD acceptance cycle, not the SFD presentation cycle.
- Back-to-back:
  - Stimulus: send_vaild held high with two descriptors.
  - Required: second accept occurs exactly IFG_CYCLES+2 cycles after the first frame's last byte; send_ready=0 throughout.
- Reset mid-frame:
  - Stimulus: reset pulsed during DATA.
  - Required: all outputs are 0 the same cycle; no send_r_vaild; after release, send_ready=1 and the next frame is complete.
- Macro off:
  - Stimulus: build without TX_TS_CORR_EN, rtc ns=999999950.
  - Required: send_r_data equals the raw capture, ns=999999950, sec unchanged.
